cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Main-memory responder for the cache's refill and spill path. It accepts cache-side memory requests (`cache_req`) on a val/rdy handshake and performs one-word reads and writes on an internal word array after a programmable latency. It returns `cache_resp` messages on a val/rdy handshake. It serves as the memory end of the cache in block-level benches and the lab3 cache composition, replacing the ideal test memory when latency and backpressure matter.

## Interface
Parameters:
- `ADDR_W`, 10: word-index width; the array holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: extra wait cycles between request accept and memory access, 0..15.
- `OPAQUE_W`, 8: opaque field width, returned unchanged in the response.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cache_req_val` input 1: request valid.
- `cache_req_rdy` output 1: responder can accept a request.
- `cache_req_type` input 1: 0 = read, 1 = write.
- `cache_req_opaque` input OPAQUE_W: tag echoed in the response.
- `cache_req_addr` input 32: byte address; the word index is addr[ADDR_W+1:2].
- `cache_req_data` input 32: write data; ignored on reads.
- `cache_resp_val` output 1: response valid.
- `cache_resp_rdy` input 1: cache ready to take the response.
- `cache_resp_type` output 1: type of the serviced request.
- `cache_resp_opaque` output OPAQUE_W: opaque value of the serviced request.
- `cache_resp_data` output 32: read data; 0 for writes.

## Operation
- FSM states: IDLE, WAIT, RESP. One request is outstanding at a time.
- IDLE: `cache_req_rdy` = 1. On `cache_req_val`, the request is accepted at the edge. At that edge, capture type, opaque, word index and data, load `cnt` with LATENCY, and go to WAIT.
- WAIT: `cache_req_rdy` = 0.
  - If `cnt` != 0: decrement `cnt` and stay in WAIT.
  - If `cnt` == 0: perform the access at the edge and go to RESP.
  - A read latches mem[idx] into the response data register.
  - A write sets mem[idx] to the captured data and sets the response data register to 0.
- RESP: `cache_resp_val` = 1, and all response fields are held stable. On `cache_resp_rdy`, the response completes at the edge and the state returns to IDLE. `cache_req_rdy` = 0 in RESP, including the handshake cycle, so there is no same-cycle bypass.
- Address bits [1:0] and bits above ADDR_W+1 are ignored. Out-of-range addresses alias modulo the array size.
- The memory array is not cleared by reset. Benches preload it through hierarchical access to the array.
- `cnt` width is 4 bits. LATENCY is not checked at runtime; values above 15 are illegal.

## Timing
- While `reset` = 0, and after release:
  - state = IDLE, `cnt` = 0.
  - `cache_resp_val` = 0, `cache_resp_type` = 0, `cache_resp_opaque` = 0, `cache_resp_data` = 0.
  - `cache_req_rdy` = 0 while reset is asserted, and 1 in the first cycle after release.
- Latency: a request accepted at edge T has its memory access at edge T+1+LATENCY. `cache_resp_val` is high in the cycle following that edge.
  - LATENCY=0: response one cycle after accept.
  - LATENCY=2: response three cycles after accept.
- Throughput: at most one request per LATENCY+3 cycles, given an immediately ready consumer.
- Backpressure: `cache_resp_val` stays high and all response fields stay unchanged until `cache_resp_rdy` is sampled high. The `cache_resp_*` outputs never depend combinationally on `cache_resp_rdy`.
- `cache_req_*` inputs are sampled only at the accept edge. Changes to them in WAIT or RESP have no effect.
- Reset asserted mid-operation (WAIT or RESP) has immediate effect: state goes to IDLE and `cache_resp_val` drops asynchronously. A write still in WAIT is dropped and leaves memory unchanged. A write whose access edge has already passed stays in memory.
- A read following a write to the same address returns the written data. Ordering is guaranteed because there is a single outstanding request.

## Test plan
- Reset, then preload mem[4] = 0xDEADBEEF. Read at addr 0x10 with opaque 0x3A and LATENCY=2, accepted at edge T. Required: `cache_resp_val` = 1 after edge T+3, data 0xDEADBEEF, opaque 0x3A, type 0; `cache_req_rdy` = 0 until the response handshake completes.
- Write 0x12345678 to addr 0x20, then read addr 0x23. Required: the write response has data 0 and type 1; the read returns 0x12345678, showing the low address bits are ignored.
- Backpressure: hold `cache_resp_rdy` = 0 for 5 cycles after `cache_resp_val` rises. Required: val and all fields are stable for 5 cycles; the state returns to IDLE one edge after `cache_resp_rdy` = 1.
- LATENCY=0 build: a read accepted at edge T has `cache_resp_val` = 1 after edge T+1. Back-to-back requests with `cache_resp_rdy` tied to 1 are accepted every 3 cycles.
- Assert reset during WAIT of a write of 0xAAAA5555 to addr 0x40 with mem[16] preloaded to 0x1. Required: `cache_resp_val` drops immediately; after release `cache_req_rdy` = 1, and a read of 0x40 returns 0x1.
- Addr 0x1010 with ADDR_W=10 aliases to word 4. Required: a read returns the mem[4] contents.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Memory end of the cache refill/spill path: one outstanding word read or write,
// serviced after a fixed number of wait cycles, with a val/rdy request and response.
module cache_mem_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned OPAQUE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cache_req_val,
    output logic                cache_req_rdy,
    input  logic                cache_req_type,
    input  logic [OPAQUE_W-1:0] cache_req_opaque,
    input  logic [31:0]         cache_req_addr,
    input  logic [31:0]         cache_req_data,
    output logic                cache_resp_val,
    input  logic                cache_resp_rdy,
    output logic                cache_resp_type,
    output logic [OPAQUE_W-1:0] cache_resp_opaque,
    output logic [31:0]         cache_resp_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state,    w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
    logic                r_req_rdy,  w_req_rdy_nxt;
    logic                r_type,     w_type_nxt;
    logic [OPAQUE_W-1:0] r_opaque,   w_opaque_nxt;
    logic [ADDR_W-1:0]   r_idx,      w_idx_nxt;
    logic [31:0]         r_wdata,    w_wdata_nxt;
    logic                r_resp_val, w_resp_val_nxt;
    logic [31:0]         r_resp_data, w_resp_data_nxt;

    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_access;
    logic                w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && r_req_rdy && cache_req_val;
    assign w_access      = (r_state == S_WAIT) && (r_cnt == '0);
    // Only the word index matters; byte offset and high bits alias.
    assign w_unused_addr = ^{cache_req_addr[31:ADDR_W+2], cache_req_addr[1:0]};

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_type_nxt      = r_type;
        w_opaque_nxt    = r_opaque;
        w_idx_nxt       = r_idx;
        w_wdata_nxt     = r_wdata;
        w_resp_val_nxt  = r_resp_val;
        w_resp_data_nxt = r_resp_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = S_WAIT;
                    w_cnt_nxt    = CNT_W'(LATENCY);
                    w_type_nxt   = cache_req_type;
                    w_opaque_nxt = cache_req_opaque;
                    w_idx_nxt    = cache_req_addr[ADDR_W+1:2];
                    w_wdata_nxt  = cache_req_data;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt     = S_RESP;
                    w_resp_val_nxt  = 1'b1;
                    w_resp_data_nxt = r_type ? 32'h0 : r_mem[r_idx];
                end
            end
            S_RESP: begin
                if (cache_resp_rdy) begin
                    w_state_nxt    = S_IDLE;
                    w_resp_val_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_resp_val_nxt = 1'b0;
            end
        endcase
        // Request side is ready only once back in IDLE, never in the handshake cycle.
        w_req_rdy_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_rdy   <= 1'b0;
            r_type      <= 1'b0;
            r_opaque    <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_resp_val  <= 1'b0;
            r_resp_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_rdy   <= w_req_rdy_nxt;
            r_type      <= w_type_nxt;
            r_opaque    <= w_opaque_nxt;
            r_idx       <= w_idx_nxt;
            r_wdata     <= w_wdata_nxt;
            r_resp_val  <= w_resp_val_nxt;
            r_resp_data <= w_resp_data_nxt;
        end
    end

    // Word array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_access && r_type) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign cache_req_rdy     = r_req_rdy;
    assign cache_resp_val    = r_resp_val;
    assign cache_resp_type   = r_type;
    assign cache_resp_opaque = r_opaque;
    assign cache_resp_data   = r_resp_data;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: a LATENCY=2 and a LATENCY=0 instance checked
// against a flat word-array model with vector tables, corner sequences and random traffic.
module tb_cache_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_val  [2];
    logic        req_rdy  [2];
    logic        req_type [2];
    logic [7:0]  req_opq  [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_data [2];
    logic        resp_val [2];
    logic        resp_rdy [2];
    logic        resp_type[2];
    logic [7:0]  resp_opq [2];
    logic [31:0] resp_data[2];

    cache_mem_responder #(.ADDR_W(10), .LATENCY(2), .OPAQUE_W(8)) dut0 (
        .clk(clk), .reset(reset),
        .cache_req_val(req_val[0]), .cache_req_rdy(req_rdy[0]), .cache_req_type(req_type[0]),
        .cache_req_opaque(req_opq[0]), .cache_req_addr(req_addr[0]), .cache_req_data(req_data[0]),
        .cache_resp_val(resp_val[0]), .cache_resp_rdy(resp_rdy[0]), .cache_resp_type(resp_type[0]),
        .cache_resp_opaque(resp_opq[0]), .cache_resp_data(resp_data[0])
    );

    cache_mem_responder #(.ADDR_W(10), .LATENCY(0), .OPAQUE_W(8)) dut1 (
        .clk(clk), .reset(reset),
        .cache_req_val(req_val[1]), .cache_req_rdy(req_rdy[1]), .cache_req_type(req_type[1]),
        .cache_req_opaque(req_opq[1]), .cache_req_addr(req_addr[1]), .cache_req_data(req_data[1]),
        .cache_resp_val(resp_val[1]), .cache_resp_rdy(resp_rdy[1]), .cache_resp_type(resp_type[1]),
        .cache_resp_opaque(resp_opq[1]), .cache_resp_data(resp_data[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [1024];

    typedef struct {
        bit          typ;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [31:0] data;
        int          hold;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One full transaction: accept, latency count, optional backpressure, handshake.
    task automatic do_req(input int d, input bit typ, input logic [7:0] opq,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int hold, input logic [31:0] exp_data);
        int n;
        int rdy_bad;
        int unstable;
        logic [41:0] snap;
        n = 0;
        while (req_rdy[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy_before_accept", 64'(req_rdy[d]), 64'd1);
        req_val[d] = 1'b1; req_type[d] = typ; req_opq[d] = opq;
        req_addr[d] = addr; req_data[d] = data;
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs: they must be ignored after the accept edge.
        req_val[d] = 1'b0; req_type[d] = ~typ; req_opq[d] = ~opq;
        req_addr[d] = $urandom; req_data[d] = $urandom;
        rdy_bad = 0;
        n = 0;
        while (resp_val[d] !== 1'b1 && n < 40) begin
            if (req_rdy[d] !== 1'b0) rdy_bad++;
            @(negedge clk);
            n++;
        end
        check("resp_latency", 64'(n), 64'(lat_of(d) + 1));
        check("resp_type", 64'(resp_type[d]), 64'(typ));
        check("resp_opaque", 64'(resp_opq[d]), 64'(opq));
        check("resp_data", 64'(resp_data[d]), 64'(exp_data));
        snap = {resp_val[d], resp_type[d], resp_opq[d], resp_data[d]};
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({resp_val[d], resp_type[d], resp_opq[d], resp_data[d]} !== snap) unstable++;
            if (req_rdy[d] !== 1'b0) rdy_bad++;
        end
        if (hold > 0) check("resp_stable_under_backpressure", 64'(unstable), 64'd0);
        resp_rdy[d] = 1'b1;
        if (req_rdy[d] !== 1'b0) rdy_bad++;
        @(negedge clk);
        resp_rdy[d] = 1'b0;
        check("req_rdy_low_while_busy", 64'(rdy_bad), 64'd0);
        check("resp_val_after_handshake", 64'(resp_val[d]), 64'd0);
        check("req_rdy_after_handshake", 64'(req_rdy[d]), 64'd1);
        if (d == 0 && typ) model[addr[11:2]] = data;
    endtask

    vec_t vecs [6];
    int   acc_cyc [$];

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_val[d] = 1'b0; req_type[d] = 1'b0; req_opq[d] = '0;
            req_addr[d] = '0; req_data[d] = '0; resp_rdy[d] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) begin
            model[i] = $urandom;
            dut0.r_mem[i] = model[i];
        end
        model[4] = 32'hDEADBEEF;
        dut0.r_mem[4] = 32'hDEADBEEF;
        dut1.r_mem[7] = 32'h0BADCAFE;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_resp_val", 64'(resp_val[0]), 64'd0);
        check("rst_req_rdy", 64'(req_rdy[0]), 64'd0);
        check("rst_resp_fields", 64'({resp_type[0], resp_opq[0], resp_data[0]}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("req_rdy_after_release", 64'(req_rdy[0]), 64'd1);

        // Directed vectors: basic read, write/read with offset bits, aliasing, backpressure
        vecs[0] = '{1'b0, 8'h3A, 32'h0000_0010, 32'h0,         0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 8'h11, 32'h0000_0020, 32'h12345678,  0, 32'h0};
        vecs[2] = '{1'b0, 8'h22, 32'h0000_0023, 32'hFFFF_FFFF, 0, 32'h12345678};
        vecs[3] = '{1'b0, 8'h33, 32'h0000_1010, 32'h0,         5, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 8'hC4, 32'h0000_1024, 32'hCAFEF00D,  2, 32'h0};
        vecs[5] = '{1'b0, 8'h55, 32'h0000_0024, 32'h0,         1, 32'hCAFEF00D};
        foreach (vecs[i])
            do_req(0, vecs[i].typ, vecs[i].opq, vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].exp_data);

        // LATENCY=0 instance: single read, then back-to-back throughput
        do_req(1, 1'b0, 8'h7E, 32'h0000_001C, 32'h0, 0, 32'h0BADCAFE);
        resp_rdy[1] = 1'b1;
        req_val[1] = 1'b1; req_type[1] = 1'b1; req_addr[1] = 32'h100; req_data[1] = 32'h5;
        for (int c = 0; c < 16; c++) begin
            if (req_rdy[1] === 1'b1) acc_cyc.push_back(c);
            @(negedge clk);
        end
        req_val[1] = 1'b0;
        check("throughput_accept_count", 64'(acc_cyc.size()), 64'd6);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("throughput_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        @(negedge clk); @(negedge clk);
        resp_rdy[1] = 1'b0;

        // Reset during WAIT of a write: write dropped
        model[16] = 32'h1;
        dut0.r_mem[16] = 32'h1;
        req_val[0] = 1'b1; req_type[0] = 1'b1; req_opq[0] = 8'h99;
        req_addr[0] = 32'h40; req_data[0] = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        req_val[0] = 1'b0;
        reset = 1'b0;
        #1;
        check("wait_reset_resp_val", 64'(resp_val[0]), 64'd0);
        check("wait_reset_req_rdy", 64'(req_rdy[0]), 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("req_rdy_after_wait_reset", 64'(req_rdy[0]), 64'd1);
        do_req(0, 1'b0, 8'h01, 32'h40, 32'h0, 0, 32'h1);

        // Reset while a response is pending: val drops asynchronously
        req_val[0] = 1'b1; req_type[0] = 1'b0; req_opq[0] = 8'h42; req_addr[0] = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_val[0] = 1'b0;
        for (int n = 0; n < 20 && resp_val[0] !== 1'b1; n++) @(negedge clk);
        check("resp_val_before_resp_reset", 64'(resp_val[0]), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("resp_reset_resp_val", 64'(resp_val[0]), 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Random traffic against the word-array model
        for (int k = 0; k < 40; k++) begin
            bit          t;
            logic [9:0]  idx;
            logic [31:0] a;
            logic [31:0] wd;
            t   = 1'($urandom_range(0, 1));
            idx = 10'($urandom_range(0, 15));
            a   = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
            wd  = $urandom;
            do_req(0, t, 8'($urandom), a, wd, $urandom_range(0, 3), t ? 32'h0 : model[idx]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
